// File: rtl/wb_arbiter_2m_if.sv
// Bus bundle for the two-master Wishbone classic arbiter.
// The "slave" modport is the arbiter's view: it receives both masters'
// requests and the slave's responses, and it drives the forwarded request
// and the routed responses. The "master" modport is the surrounding
// system's view of the same wires.
//
// Handshake: Wishbone classic. A request is live while cyc and stb are
// both high, and the master holds cyc, stb, we, adr, dat and sel stable
// until it sees ack, err or rty. A response completes the transfer in the
// cycle in which it is sampled high.
interface wb_arbiter_2m_if #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
);
    logic [1:0]             m_cyc_i;
    logic [1:0]             m_stb_i;
    logic [1:0]             m_we_i;
    logic [2*ADR_W-1:0]     m_adr_i;
    logic [2*DAT_W-1:0]     m_dat_i;
    logic [2*DAT_W/8-1:0]   m_sel_i;
    logic [DAT_W-1:0]       m_dat_o;
    logic [1:0]             m_ack_o;
    logic [1:0]             m_err_o;
    logic [1:0]             m_rty_o;

    logic                   s_cyc_o;
    logic                   s_stb_o;
    logic                   s_we_o;
    logic [ADR_W-1:0]       s_adr_o;
    logic [DAT_W-1:0]       s_dat_o;
    logic [DAT_W/8-1:0]     s_sel_o;
    logic [DAT_W-1:0]       s_dat_i;
    logic                   s_ack_i;
    logic                   s_err_i;
    logic                   s_rty_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin priority.
// The owner keeps the bus from cyc assert to cyc drop (no preemption); on a
// tie in IDLE the master that did not own the bus last wins.
// Optional bus watchdog: define WB_ARB_TIMEOUT_EN to force a one-cycle err
// to the owner after TIMEOUT_CYCLES strobed cycles without a slave response.
module wb_arbiter_2m #(
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wb_arbiter_2m_if.slave       bus,
    output logic [1:0]           grant_o,
    output logic [1:0]           dbg_state_o
);
    localparam int SEL_W = DAT_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   own0, own1;
    logic   wdog_fire;

    assign own0        = (state_q == OWN0);
    assign own1        = (state_q == OWN1);
    assign grant_o     = {own1, own0};
    assign dbg_state_o = state_q;

    // State and round-robin history registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next owner: arbitrate from IDLE, hand over directly when the owner drops cyc.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                case (bus.m_cyc_i)
                    2'b01:   state_d = OWN0;
                    2'b10:   state_d = OWN1;
                    2'b11:   state_d = last_q ? OWN0 : OWN1;
                    default: state_d = IDLE;
                endcase
            end
            OWN0: begin
                if (!bus.m_cyc_i[0]) begin
                    last_d  = 1'b0;
                    state_d = bus.m_cyc_i[1] ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!bus.m_cyc_i[1]) begin
                    last_d  = 1'b1;
                    state_d = bus.m_cyc_i[0] ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Forward the owner's request to the slave; everything is zero in IDLE.
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        if (own0) begin
            bus.s_cyc_o = bus.m_cyc_i[0];
            bus.s_stb_o = bus.m_stb_i[0];
            bus.s_we_o  = bus.m_we_i[0];
            bus.s_adr_o = bus.m_adr_i[0 +: ADR_W];
            bus.s_dat_o = bus.m_dat_i[0 +: DAT_W];
            bus.s_sel_o = bus.m_sel_i[0 +: SEL_W];
        end else if (own1) begin
            bus.s_cyc_o = bus.m_cyc_i[1];
            bus.s_stb_o = bus.m_stb_i[1];
            bus.s_we_o  = bus.m_we_i[1];
            bus.s_adr_o = bus.m_adr_i[ADR_W +: ADR_W];
            bus.s_dat_o = bus.m_dat_i[DAT_W +: DAT_W];
            bus.s_sel_o = bus.m_sel_i[SEL_W +: SEL_W];
        end
    end

    // Route responses to the owner only; read data is broadcast.
    always_comb begin
        bus.m_dat_o = bus.s_dat_i;
        bus.m_ack_o = {own1 & bus.s_ack_i, own0 & bus.s_ack_i};
        bus.m_err_o = {own1 & (bus.s_err_i | wdog_fire),
                       own0 & (bus.s_err_i | wdog_fire)};
        bus.m_rty_o = {own1 & bus.s_rty_i, own0 & bus.s_rty_i};
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wdog_q;
    logic             slave_resp;

    assign slave_resp = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
    assign wdog_fire  = (wdog_q == CNT_W'(TIMEOUT_CYCLES));

    // Watchdog: count unanswered strobed cycles; restart on any response,
    // on ownership change, and after firing.
    always_ff @(posedge clk_i) begin
        if (rst_i || slave_resp || wdog_fire || (state_d != state_q)) begin
            wdog_q <= '0;
        end else if (bus.s_stb_o) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end
`else
    // No watchdog: the expression is constant false for any sane limit.
    assign wdog_fire = (TIMEOUT_CYCLES < 0);
`endif
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: arbitration, handover, routing, reset
// and the optional watchdog. Read data is tracked through an expected queue.
module tb_wb_arbiter_2m;
    localparam int ADR_W   = 32;
    localparam int DAT_W   = 32;
    localparam int TIMEOUT = 4;

    logic       clk;
    logic       rst;
    logic [1:0] grant;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // {ack vector, read data}
    logic [33:0] exp_q[$];

    wb_arbiter_2m_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

    wb_arbiter_2m #(
        .ADR_W          (ADR_W),
        .DAT_W          (DAT_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .grant_o     (grant),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        bus.m_we_i  = 2'b00;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
        bus.s_rty_i = 1'b0;
    endtask

    // Scoreboard: every ack seen by a master must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && bus.m_ack_o !== 2'b00) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_ack observed=%0h expected=none", bus.m_ack_o);
            end
            if (exp_q.size() != 0) begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("sb_ack_vec", {62'd0, bus.m_ack_o}, {62'd0, e[33:32]});
                chk("sb_rdata", {32'd0, bus.m_dat_o}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        int own;
        int lat;
        int first;
        int n;
        logic [31:0] data;
        logic [31:0] own_adr;

        // Reset
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk("rst_grant", {62'd0, grant}, 64'd0);
        chk("rst_state", {62'd0, dbg_state}, 64'd0);
        chk("rst_scyc", {63'd0, bus.s_cyc_o}, 64'd0);
        chk("rst_ack", {62'd0, bus.m_ack_o}, 64'd0);
        rst = 1'b0;

        // Both request together: master 0 wins the first tie, one cycle later
        bus.m_adr_i = {32'h0000_0200, 32'h0000_0100};
        bus.m_cyc_i = 2'b11;
        bus.m_stb_i = 2'b11;
        settle();
        chk("t1_pre_grant", {62'd0, grant}, 64'd0);
        chk("t1_pre_scyc", {63'd0, bus.s_cyc_o}, 64'd0);
        tick();
        chk("t1_grant", {62'd0, grant}, 64'd1);
        chk("t1_sadr", {32'd0, bus.s_adr_o}, 64'h100);
        chk("t1_scyc", {63'd0, bus.s_cyc_o}, 64'd1);
        chk("t1_sstb", {63'd0, bus.s_stb_o}, 64'd1);

        // Continuous requests from both: ownership alternates with no idle gap
        for (int i = 0; i < 4; i++) begin
            own     = i % 2;
            own_adr = (own == 1) ? 32'h200 : 32'h100;
            chk("rr_grant", {62'd0, grant}, (own == 1) ? 64'd2 : 64'd1);
            chk("rr_sadr", {32'd0, bus.s_adr_o}, {32'd0, own_adr});
            lat  = (i == 0) ? 2 : $urandom_range(0, 2);
            data = (i == 0) ? 32'hDEAD_BEEF : $urandom;
            for (int j = 0; j < lat; j++) begin
                chk("rr_no_ack_yet", {62'd0, bus.m_ack_o}, 64'd0);
                tick();
            end
            bus.s_dat_i = data;
            bus.s_ack_i = 1'b1;
            exp_q.push_back({((own == 1) ? 2'b10 : 2'b01), data});
            tick();
            bus.s_ack_i = 1'b0;
            bus.m_cyc_i[own] = 1'b0;
            bus.m_stb_i[own] = 1'b0;
            settle();
            chk("rr_drop_scyc", {63'd0, bus.s_cyc_o}, 64'd0);
            tick();
            bus.m_cyc_i[own] = 1'b1;
            bus.m_stb_i[own] = 1'b1;
            settle();
        end
        chk("rr_end_grant", {62'd0, grant}, 64'd1);

        // Master 1 write with sel=0100; master 0 cannot preempt
        bus.m_cyc_i = 2'b10;
        bus.m_stb_i = 2'b10;
        tick();
        bus.m_we_i  = 2'b10;
        bus.m_sel_i = {4'b0100, 4'b1111};
        bus.m_dat_i = {32'h1234_5678, 32'hA5A5_A5A5};
        bus.m_adr_i = {32'h0000_0300, 32'h0000_0100};
        settle();
        chk("t4_grant", {62'd0, grant}, 64'd2);
        chk("t4_ssel", {60'd0, bus.s_sel_o}, 64'h4);
        chk("t4_swe", {63'd0, bus.s_we_o}, 64'd1);
        chk("t4_sdat", {32'd0, bus.s_dat_o}, 64'h1234_5678);
        chk("t4_sadr", {32'd0, bus.s_adr_o}, 64'h300);
        bus.m_cyc_i[0] = 1'b1;
        bus.m_stb_i[0] = 1'b1;
        tick();
        chk("t4_no_preempt", {62'd0, grant}, 64'd2);
        chk("t4_ssel_held", {60'd0, bus.s_sel_o}, 64'h4);
        bus.s_dat_i = 32'h0;
        bus.s_ack_i = 1'b1;
        exp_q.push_back({2'b10, 32'h0});
        tick();
        bus.s_ack_i    = 1'b0;
        bus.m_cyc_i[1] = 1'b0;
        bus.m_stb_i[1] = 1'b0;
        bus.m_we_i     = 2'b00;
        settle();
        chk("t4_hold_to_edge", {62'd0, grant}, 64'd2);
        tick();
        chk("t4_handover", {62'd0, grant}, 64'd1);
        chk("t4_ssel_m0", {60'd0, bus.s_sel_o}, 64'hF);

        // Reset while master 1 waits on its strobe; round-robin history resets too
        bus.m_cyc_i = 2'b10;
        bus.m_stb_i = 2'b10;
        tick();
        chk("t5_own1", {62'd0, grant}, 64'd2);
        rst = 1'b1;
        bus.m_cyc_i = 2'b11;
        bus.m_stb_i = 2'b11;
        tick();
        rst = 1'b0;
        chk("t5_rst_scyc", {63'd0, bus.s_cyc_o}, 64'd0);
        chk("t5_rst_sstb", {63'd0, bus.s_stb_o}, 64'd0);
        chk("t5_rst_grant", {62'd0, grant}, 64'd0);
        tick();
        chk("t5_m0_first", {62'd0, grant}, 64'd1);

        // err and rty routed to the owner only
        bus.s_err_i = 1'b1;
        settle();
        chk("route_err", {62'd0, bus.m_err_o}, 64'd1);
        bus.s_err_i = 1'b0;
        bus.s_rty_i = 1'b1;
        settle();
        chk("route_rty", {62'd0, bus.m_rty_o}, 64'd1);
        bus.s_rty_i = 1'b0;

        // Responses in IDLE are dropped; slave side is all zero
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        tick();
        bus.s_ack_i = 1'b1;
        bus.s_err_i = 1'b1;
        bus.s_rty_i = 1'b1;
        settle();
        chk("idle_grant", {62'd0, grant}, 64'd0);
        chk("idle_ack", {62'd0, bus.m_ack_o}, 64'd0);
        chk("idle_err", {62'd0, bus.m_err_o}, 64'd0);
        chk("idle_rty", {62'd0, bus.m_rty_o}, 64'd0);
        chk("idle_sadr", {32'd0, bus.s_adr_o}, 64'd0);
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
        bus.s_rty_i = 1'b0;

        // Hung slave
        bus.m_cyc_i = 2'b01;
        bus.m_stb_i = 2'b01;
        tick();
        first = -1;
        n     = 0;
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            if (bus.m_err_o != 2'b00) begin
                n++;
                if (first < 0) first = k;
                chk("wdog_err_vec", {62'd0, bus.m_err_o}, 64'd1);
            end
            tick();
        end
        chk("wdog_first_cycle", 64'(first), 64'd4);
        chk("wdog_pulse_count", 64'(n), 64'd1);
`else
        for (int k = 0; k < 100; k++) begin
            if (bus.m_err_o != 2'b00) n++;
            tick();
        end
        chk("no_wdog_err", 64'(n), 64'd0);
        chk("no_wdog_still_owned", {62'd0, grant}, 64'd1);
`endif
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        tick();

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone classic arbiter with round-robin priority.
- Lets the CPU share the system bus with a second master (DMA or debug).
- The owning master's request signals are forwarded to the slave.
- Slave responses are routed back to the owning master only.
- Ownership is held for a whole cycle, from cyc assert to cyc drop.

Parameters:
- ADR_W, 32, address width per master.
- DAT_W, 32, data width. Select width is DAT_W/8.
- TIMEOUT_CYCLES, 255, bus watchdog limit. Used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk_i  input  1  system clock. Every register updates on its rising edge.
- rst_i  input  1  reset. Synchronous, active-high.
- m_cyc_i  input  2  bus cycle request per master. Bit n belongs to master n.
- m_stb_i  input  2  strobe per master.
- m_we_i  input  2  write enable per master.
- m_adr_i  input  2*ADR_W  addresses, packed. Master n uses [n*ADR_W +: ADR_W].
- m_dat_i  input  2*DAT_W  write data, packed.
- m_sel_i  input  2*DAT_W/8  byte selects, packed.
- m_dat_o  output  DAT_W  read data. Equal to s_dat_i, broadcast to both masters.
- m_ack_o  output  2  ack per master.
- m_err_o  output  2  err per master.
- m_rty_o  output  2  rty per master.
- s_cyc_o  output  1  slave cycle.
- s_stb_o  output  1  slave strobe.
- s_we_o  output  1  slave write enable.
- s_adr_o  output  ADR_W  slave address.
- s_dat_o  output  DAT_W  slave write data.
- s_sel_o  output  DAT_W/8  slave byte selects.
- s_dat_i  input  DAT_W  slave read data.
- s_ack_i  input  1  slave ack.
- s_err_i  input  1  slave err.
- s_rty_i  input  1  slave rty.
- grant_o  output  2  one-hot current owner. 00 when idle. Registered.

Behaviour:
- State machine states: IDLE, OWN0, OWN1. grant_o is decoded from the state.
- Register last: the most recent owner. Reset value is 1, so master 0 wins the first tie.
- IDLE transitions:
  - Only m_cyc_i[n] set -> OWNn.
  - Both set -> the master that is not last.
  - Neither set -> stay in IDLE.
  - Arbitration latency is one cycle: a request seen at edge k is granted from edge k onward.
  - s_cyc_o asserts in the cycle after the request first appears.
- OWNn transitions:
  - Hold while m_cyc_i[n]=1. The other master's requests are ignored; there is no preemption.
  - When m_cyc_i[n]=0 at an edge: last<=n. Go to OWN(1-n) if m_cyc_i[1-n]=1, else IDLE.
  - This gives a back-to-back handover with no idle cycle.
- Slave side outputs (combinational mux from the registered owner):
  - s_cyc_o = m_cyc_i[n] & (state==OWNn).
  - s_stb_o = m_stb_i[n] & (state==OWNn).
  - we, adr, dat and sel follow the owner.
  - In IDLE: s_cyc_o=0, s_stb_o=0, s_we_o=0, s_adr_o=0, s_dat_o=0, s_sel_o=0.
- Response routing:
  - m_ack_o[n] = s_ack_i & (state==OWNn). err and rty are routed the same way.
  - The non-owner always sees 0.
  - Slave responses in IDLE are dropped.
- Owner drops cyc mid-transfer with no ack: the cycle is abandoned and ownership released as above. The slave sees s_cyc_o fall in the same cycle.
- Reset:
  - rst_i=1 at an edge -> IDLE, last<=1, watchdog counter cleared.
  - This applies even mid-transfer. s_cyc_o, s_stb_o and grant_o are 0 in the following cycle.
  - All response outputs are 0 in IDLE.
- A master must hold cyc, stb and address stable until it receives ack, err or rty (Wishbone classic). The arbiter does not register the request.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1).
  - Increments each cycle with s_stb_o=1 and s_ack_i=s_err_i=s_rty_i=0.
  - Clears on any slave response, on ownership change, and on reset.
  - When count==TIMEOUT_CYCLES, m_err_o[owner] is forced to 1 for that single cycle and the counter clears.
  - s_stb_o remains as driven by the master.
- Undefined: no counter exists, TIMEOUT_CYCLES is unused, and a hung slave stalls the owner forever.

Test Plan:
- Reset, then m_cyc_i=11 on the same cycle -> next cycle grant_o=01. Master 0's address 0x100 appears on s_adr_o. m_ack_o=00 until s_ack_i.
- Master 0 read, slave acks on the third cycle with s_dat_i=0xDEADBEEF -> m_ack_o=01 for one cycle and m_dat_o=0xDEADBEEF. m_ack_o[1] stays 0 throughout.
- Both masters request continuously, each dropping cyc one cycle after its ack -> grants alternate 01,10,01,10 with no IDLE cycle between owners.
- Master 1 owns the bus and asserts a write with sel=0100. Master 0 requests mid-transfer -> grant stays 10 until m_cyc_i[1]=0, then becomes 01 on the next edge. s_sel_o=0100 during master 1's write.
- rst_i pulsed while OWN1 with stb waiting -> next cycle s_cyc_o=0, grant_o=00. With both then requesting, master 0 is granted first.
- WB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and the slave never acks -> m_err_o[owner]=1 exactly 4 cycles after the first s_stb_o cycle, for one cycle. Without the macro: no err after 100 cycles.
